// File: rtl/pp_pkg.sv
// Shared definitions for the 12-bit sequencer program-counter stage:
// address width, instruction-class codes, interrupt vector and flow decoding.
package pp_pkg;

    localparam int AW = 12;

    localparam logic [3:0] KIND_NOP  = 4'b0000;
    localparam logic [3:0] KIND_BCC  = 4'b0100;
    localparam logic [3:0] KIND_JMP  = 4'b0101;
    localparam logic [3:0] KIND_JSB  = 4'b0110;
    localparam logic [3:0] KIND_RET  = 4'b0111;
    localparam logic [3:0] KIND_RETI = 4'b1000;
    localparam logic [3:0] KIND_ENAI = 4'b1001;
    localparam logic [3:0] KIND_DISI = 4'b1010;

    localparam logic [AW-1:0] INT_VECTOR = 12'h001;

    // Instructions that redirect flow must never be pre-empted by an interrupt.
    function automatic logic ctl_flow(input logic [3:0] kind);
        logic flow;
        case (kind)
            KIND_BCC, KIND_JMP, KIND_JSB, KIND_RET, KIND_RETI: flow = 1'b1;
            default:                                           flow = 1'b0;
        endcase
        return flow;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// DEPTH x AW return-address LIFO with registered top-of-stack, occupancy
// and sticky overflow/underflow flags.
module ret_stack
    import pp_pkg::*;
#(
    parameter int AW    = pp_pkg::AW,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              din,
    output logic [AW-1:0]              top,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       ovf,
    output logic                       unf
);

    localparam int AI = $clog2(DEPTH);
    localparam int DW = AI + 1;

    logic [AW-1:0] mem_r [DEPTH];
    logic [AW-1:0] top_r;
    logic [DW-1:0] depth_r;
    logic          ovf_r;
    logic          unf_r;
    logic          full_s;
    logic          empty_s;
    logic [AI-1:0] below_idx_s;

    assign full_s      = (depth_r == DW'(DEPTH));
    assign empty_s     = (depth_r == {DW{1'b0}});
    assign below_idx_s = AI'(depth_r - DW'(2));

    // Stack update; a push when full overwrites the top slot, a pop when empty is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {AW{1'b0}};
            end
            top_r   <= {AW{1'b0}};
            depth_r <= {DW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (push) begin
            top_r <= din;
            if (full_s) begin
                mem_r[DEPTH-1] <= din;
                ovf_r          <= 1'b1;
            end else begin
                mem_r[depth_r[AI-1:0]] <= din;
                depth_r                <= depth_r + DW'(1);
            end
        end else if (pop) begin
            if (empty_s) begin
                unf_r <= 1'b1;
            end else begin
                depth_r <= depth_r - DW'(1);
                top_r   <= (depth_r >= DW'(2)) ? mem_r[below_idx_s] : {AW{1'b0}};
            end
        end else begin
            top_r <= top_r;
        end
    end

    assign top   = top_r;
    assign depth = depth_r;
    assign ovf   = ovf_r;
    assign unf   = unf_r;

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter stage: PC, return stack, interrupt enable/acknowledge,
// saved interrupt PC and the int_req_n synchroniser feeding the next-address mux.
module pc_stack_unit
    import pp_pkg::*;
#(
    parameter int AW    = pp_pkg::AW,
    parameter int DEPTH = 8,
    parameter int SYNC  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pc_we,
    input  logic [3:0]             kind,
    input  logic [AW-1:0]          next_addr,
    input  logic                   int_req_n,
    output logic [AW-1:0]          pc,
    output logic [AW-1:0]          one_addr,
    output logic [AW-1:0]          stack_d,
    output logic [AW-1:0]          int_pc,
    output logic                   int_req,
    output logic                   int_en,
    output logic                   int_ack,
    output logic [$clog2(DEPTH):0] stk_depth,
    output logic                   stk_ovf,
    output logic                   stk_unf
);

    logic [AW-1:0]   pc_r;
    logic [AW-1:0]   int_pc_r;
    logic            ie_r;
    logic            int_ack_r;
    logic [SYNC-1:0] sync_r;
    logic            int_en_s;
    logic            take_s;
    logic            push_s;
    logic            pop_s;

    assign one_addr = pc_r + AW'(1);
    assign int_en_s = ie_r & ~ctl_flow(kind);
    // Same equation the mux uses to select the vector, so both sides agree on a take.
    assign take_s   = pc_we & int_en_s & ~sync_r[SYNC-1] & ~int_ack_r;
    assign push_s   = pc_we & (kind == KIND_JSB);
    assign pop_s    = pc_we & (kind == KIND_RET);

    // Request synchroniser shifts every cycle, independent of pc_we.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC-2:0], int_req_n};
        end
    end

    // Architectural PC and interrupt state, committed only on an advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r      <= {AW{1'b0}};
            int_pc_r  <= {AW{1'b0}};
            ie_r      <= 1'b0;
            int_ack_r <= 1'b0;
        end else if (pc_we) begin
            pc_r <= next_addr;
            case (kind)
                KIND_ENAI: ie_r <= 1'b1;
                KIND_DISI: ie_r <= 1'b0;
                default:   ie_r <= ie_r;
            endcase
            if (take_s) begin
                int_pc_r  <= one_addr;
                int_ack_r <= 1'b1;
            end else if (kind == KIND_RETI) begin
                int_ack_r <= 1'b0;
            end else begin
                int_ack_r <= int_ack_r;
            end
        end else begin
            pc_r <= pc_r;
        end
    end

    ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (one_addr),
        .top   (stack_d),
        .depth (stk_depth),
        .ovf   (stk_ovf),
        .unf   (stk_unf)
    );

    assign pc      = pc_r;
    assign int_pc  = int_pc_r;
    assign int_req = sync_r[SYNC-1];
    assign int_en  = int_en_s;
    assign int_ack = int_ack_r;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: the bench plays the next-address mux with
// hand-computed next_addr values and checks against hand-computed expectations.
module tb_pc_stack_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_we;
    logic [3:0]  kind;
    logic [11:0] next_addr;
    logic        int_req_n;
    logic [11:0] pc, one_addr, stack_d, int_pc;
    logic        int_req, int_en, int_ack, stk_ovf, stk_unf;
    logic [3:0]  stk_depth;

    int total = 0;
    int bad   = 0;

    pc_stack_unit #(.AW(12), .DEPTH(8), .SYNC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_we     (pc_we),
        .kind      (kind),
        .next_addr (next_addr),
        .int_req_n (int_req_n),
        .pc        (pc),
        .one_addr  (one_addr),
        .stack_d   (stack_d),
        .int_pc    (int_pc),
        .int_req   (int_req),
        .int_en    (int_en),
        .int_ack   (int_ack),
        .stk_depth (stk_depth),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // One advance with the given instruction class and mux output.
    task automatic step(input logic [3:0] k, input logic [11:0] na);
        kind      = k;
        next_addr = na;
        pc_we     = 1'b1;
        @(posedge clk);
        #1;
        pc_we     = 1'b0;
        kind      = 4'b0000;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic peek_en(input string tag, input logic [3:0] k, input logic exp);
        kind = k;
        #1;
        check_eq(tag, {31'd0, int_en}, {31'd0, exp});
        kind = 4'b0000;
    endtask

    initial begin
        rst_n     = 1'b0;
        pc_we     = 1'b0;
        kind      = 4'b0000;
        next_addr = 12'h000;
        int_req_n = 1'b1;
        idle();
        idle();
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_pc", {20'd0, pc}, 32'h000);
        check_eq("rst_stack_d", {20'd0, stack_d}, 32'h000);
        check_eq("rst_depth", {28'd0, stk_depth}, 32'd0);
        check_eq("rst_int_ack", {31'd0, int_ack}, 32'd0);
        check_eq("rst_int_pc", {20'd0, int_pc}, 32'h000);
        check_eq("rst_int_req", {31'd0, int_req}, 32'd1);
        check_eq("rst_int_en", {31'd0, int_en}, 32'd0);

        // Sequential fetch
        for (int i = 1; i <= 3; i++) begin
            step(4'b0000, 12'(i));
            check_eq("seq_pc", {20'd0, pc}, 32'(i));
        end
        check_eq("seq_one_addr", {20'd0, one_addr}, 32'h004);
        check_eq("seq_int_en", {31'd0, int_en}, 32'd0);

        // Call and return
        step(4'b0000, 12'h010);
        step(4'b0110, 12'h200);
        check_eq("jsb_pc", {20'd0, pc}, 32'h200);
        check_eq("jsb_stack_d", {20'd0, stack_d}, 32'h011);
        check_eq("jsb_depth", {28'd0, stk_depth}, 32'd1);
        step(4'b0111, 12'h011);
        check_eq("ret_pc", {20'd0, pc}, 32'h011);
        check_eq("ret_depth", {28'd0, stk_depth}, 32'd0);
        check_eq("ret_stack_d", {20'd0, stack_d}, 32'h000);

        // pc_we=0 holds everything
        kind      = 4'b0110;
        next_addr = 12'h555;
        idle();
        check_eq("hold_pc", {20'd0, pc}, 32'h011);
        check_eq("hold_depth", {28'd0, stk_depth}, 32'd0);
        kind = 4'b0000;

        // one_addr wraps
        step(4'b0000, 12'hFFF);
        check_eq("wrap_one_addr", {20'd0, one_addr}, 32'h000);

        // Nine calls into an 8-deep stack
        step(4'b0000, 12'h100);
        for (int i = 0; i < 9; i++) begin
            step(4'b0110, 12'(12'h110 + 12'(i * 16)));
        end
        check_eq("ovf_flag", {31'd0, stk_ovf}, 32'd1);
        check_eq("ovf_depth", {28'd0, stk_depth}, 32'd8);
        check_eq("ovf_stack_d", {20'd0, stack_d}, 32'h181);
        step(4'b0111, 12'h181);
        check_eq("pop1_stack_d", {20'd0, stack_d}, 32'h161);
        check_eq("pop1_depth", {28'd0, stk_depth}, 32'd7);
        for (int i = 0; i < 7; i++) begin
            step(4'b0111, 12'(12'h151 - 12'(i * 16)));
        end
        check_eq("drain_depth", {28'd0, stk_depth}, 32'd0);
        check_eq("drain_unf", {31'd0, stk_unf}, 32'd0);
        step(4'b0111, 12'h033);
        check_eq("unf_flag", {31'd0, stk_unf}, 32'd1);
        check_eq("unf_pc", {20'd0, pc}, 32'h033);
        check_eq("unf_depth", {28'd0, stk_depth}, 32'd0);
        check_eq("unf_stack_d", {20'd0, stack_d}, 32'h000);

        // Enable, request, take
        step(4'b1001, 12'h050);
        peek_en("en_nop", 4'b0000, 1'b1);
        int_req_n = 1'b0;
        idle();
        check_eq("sync_1", {31'd0, int_req}, 32'd1);
        idle();
        check_eq("sync_2", {31'd0, int_req}, 32'd0);
        check_eq("pre_take_pc", {20'd0, pc}, 32'h050);
        step(4'b0000, 12'h001);
        check_eq("take_pc", {20'd0, pc}, 32'h001);
        check_eq("take_int_pc", {20'd0, int_pc}, 32'h051);
        check_eq("take_int_ack", {31'd0, int_ack}, 32'd1);
        step(4'b0000, 12'h002);
        check_eq("noreentry_int_pc", {20'd0, int_pc}, 32'h051);
        check_eq("noreentry_ack", {31'd0, int_ack}, 32'd1);

        // Return from interrupt with request still low, then re-entry
        peek_en("en_reti", 4'b1000, 1'b0);
        step(4'b1000, 12'h051);
        check_eq("reti_pc", {20'd0, pc}, 32'h051);
        check_eq("reti_ack", {31'd0, int_ack}, 32'd0);
        step(4'b0000, 12'h001);
        check_eq("reenter_ack", {31'd0, int_ack}, 32'd1);
        check_eq("reenter_int_pc", {20'd0, int_pc}, 32'h052);
        step(4'b1000, 12'h052);
        check_eq("reti2_ack", {31'd0, int_ack}, 32'd0);

        // Branch is never pre-empted; the next plain instruction is
        peek_en("en_bcc", 4'b0100, 1'b0);
        step(4'b0100, 12'h300);
        check_eq("bcc_pc", {20'd0, pc}, 32'h300);
        check_eq("bcc_ack", {31'd0, int_ack}, 32'd0);
        step(4'b0000, 12'h001);
        check_eq("post_bcc_ack", {31'd0, int_ack}, 32'd1);
        check_eq("post_bcc_int_pc", {20'd0, int_pc}, 32'h301);

        // DISI clears the enable; ENAI restores it
        step(4'b1010, 12'h002);
        peek_en("en_after_disi", 4'b0000, 1'b0);
        step(4'b1001, 12'h003);
        peek_en("en_after_enai", 4'b0000, 1'b1);

        // Reset during service with a call pending
        rst_n     = 1'b0;
        pc_we     = 1'b1;
        kind      = 4'b0110;
        next_addr = 12'h444;
        @(posedge clk);
        #1;
        pc_we = 1'b0;
        kind  = 4'b0000;
        #1;
        check_eq("mid_rst_pc", {20'd0, pc}, 32'h000);
        check_eq("mid_rst_ack", {31'd0, int_ack}, 32'd0);
        check_eq("mid_rst_int_pc", {20'd0, int_pc}, 32'h000);
        check_eq("mid_rst_int_en", {31'd0, int_en}, 32'd0);
        check_eq("mid_rst_depth", {28'd0, stk_depth}, 32'd0);
        check_eq("mid_rst_ovf", {31'd0, stk_ovf}, 32'd0);
        check_eq("mid_rst_unf", {31'd0, stk_unf}, 32'd0);
        check_eq("mid_rst_int_req", {31'd0, int_req}, 32'd1);
        rst_n     = 1'b1;
        int_req_n = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
